mcycle_unit: RTL and testbench
==============================

Name: mcycle_unit

Overview:
Parametrised multi-cycle multiply/divide unit for the Execute stage of the pipelined core. It supports signed and unsigned multiply and divide at WIDTH bits, with a flush input so a squashed instruction can be abandoned mid-operation. The Busy output drives the hazard unit's stall of the F/D/E stages. Operands come from the forwarded SrcA/WriteData paths, and Result1 feeds the E-stage result mux.

Parameters:
WIDTH, 32, operand width in bits (legal range 4..64).
DIV0_QUOTIENT, all ones (WIDTH bits), quotient returned on divide-by-zero.

Ports:
CLK  in  1  clock; all state updates on the rising edge.
Reset_n  in  1  reset, asynchronous, active-low.
Start  in  1  request; sampled only in IDLE.
Op  in  2  operation: 00 unsigned mul, 01 signed mul, 10 unsigned div, 11 signed div.
Flush  in  1  abort current or requested operation.
Operand1  in  WIDTH  multiplicand / dividend.
Operand2  in  WIDTH  multiplier / divisor.
Result1  out  WIDTH  product low half / quotient.
Result2  out  WIDTH  product high half / remainder.
Busy  out  1  unit occupied; stall request.
Done  out  1  one-cycle pulse, results valid.

Behaviour:
- Reset (Reset_n=0, asynchronous): state=IDLE, Result1=Result2=0, Done=0, Busy=0, internal counter and registers=0.
- States: IDLE, COMPUTE, FINISH.
- IDLE:
  - Start=1 and Flush=0: capture Op and operands, set count=0, go to COMPUTE.
  - Divide with Operand2=0: go to FINISH instead of COMPUTE.
  - Flush=1: no capture, stay in IDLE.
- Busy (combinational) = (IDLE & Start & ~Flush) | COMPUTE. Busy rises in the same cycle as Start so the hazard unit stalls immediately.
- Start is ignored while not in IDLE.
- COMPUTE: exactly WIDTH iterations, one per clock. count increments 0..WIDTH-1; on the edge where count=WIDTH-1, go to FINISH.
  - Multiply: radix-2 shift-add on magnitudes with a 2*WIDTH accumulator.
  - Divide: restoring division on magnitudes, with a WIDTH+1-bit partial remainder.
- Signed ops:
  - At capture, take absolute values of both operands as unsigned WIDTH-bit (the most-negative value maps to 2^(WIDTH-1)).
  - Signed mul: negate the 2*WIDTH product if the operand signs differ.
  - Signed div: quotient truncates toward zero; negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Overflow case (most-negative / -1): Quotient = most-negative, Remainder = 0. No trap.
- Divide-by-zero: Result1=DIV0_QUOTIENT, Result2=Operand1 (unmodified, any sign).
- FINISH (one cycle):
  - Done=1 and Busy=0.
  - Result1/Result2 are registered on entry, so they are valid during Done.
  - Next state is IDLE.
  - A Start in FINISH is ignored; the core issues the next op in IDLE.
- Latency:
  - Start at edge 0 gives Done high in the cycle after edge WIDTH+1 (WIDTH+1 cycles).
  - Divide-by-zero gives Done in the cycle after edge 1.
- Result1/Result2 hold their value from Done until the next FINISH. They are not cleared by Start or Flush.
- Flush in COMPUTE: next edge goes to IDLE. No Done, results unchanged, Busy low the following cycle.
- Flush in FINISH: Done still pulses and results still update. The pipeline's FlushM discards the writeback.
- Reset mid-operation: immediately IDLE with all outputs 0. No Done.
- Width rules: all internal arithmetic is unsigned, 2*WIDTH for the product and WIDTH+1 for the remainder. No sign-extension beyond WIDTH on outputs.

Test Plan:
1. WIDTH=32, Op=00, 0xFFFFFFFF*0xFFFFFFFF -> Busy high from the Start cycle; Done in cycle 33; Result2=0xFFFFFFFE, Result1=0x00000001.
2. Op=01, -3*7 -> Result1=0xFFFFFFEB, Result2=0xFFFFFFFF. Op=01, 0x80000000*0x80000000 -> Result2=0x40000000, Result1=0.
3. Op=11, -7/2 -> Result1=0xFFFFFFFD, Result2=0xFFFFFFFF. Op=10, 100/7 -> Result1=14, Result2=2. Each Done after 33 cycles.
4. Op=10, 5/0 -> Done the cycle after edge 1; Result1=0xFFFFFFFF, Result2=5. Op=11, -5/0 -> Result2=0xFFFFFFFB.
5. Flush in COMPUTE at count=10 -> Busy low next cycle, Done never asserts, results keep prior values. Start+Flush together in IDLE -> Busy=0, no capture. A following Start completes normally.
6. WIDTH=8:
   - Op=11, 0x80/0xFF -> Result1=0x80, Result2=0x00, Done after 9 cycles.
   - Reset_n pulled low at count=4 -> Busy=Done=0 and results=0 asynchronously; no Done after release.

Source files
------------

// File: rtl/mcycle_unit.sv
// Multi-cycle multiply/divide unit for the Execute stage: WIDTH-step shift-add
// multiply and restoring divide on operand magnitudes, with sign fix-up at the end.
module mcycle_unit #(
    parameter int               WIDTH         = 32,
    parameter logic [WIDTH-1:0] DIV0_QUOTIENT = {WIDTH{1'b1}}
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic             Flush,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done
);
    localparam int CNT_W  = $clog2(WIDTH) + 1;
    localparam int PROD_W = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        FINISH  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [CNT_W-1:0]  count;
    logic              is_div;
    logic              neg_res;
    logic              neg_rem;
    logic [WIDTH-1:0]  operand;
    logic [WIDTH-1:0]  part;
    logic [WIDTH-1:0]  shreg;

    logic              accept;
    logic              div_zero;
    logic              last_iter;
    logic [WIDTH:0]    mul_sum;
    logic [WIDTH:0]    div_shift;
    logic [WIDTH:0]    div_diff;
    logic              div_fits;
    logic [WIDTH-1:0]  part_next;
    logic [WIDTH-1:0]  shreg_next;
    logic [PROD_W-1:0] product;
    logic [WIDTH-1:0]  res1_final;
    logic [WIDTH-1:0]  res2_final;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    function automatic logic [PROD_W-1:0] negate_wide(input logic [PROD_W-1:0] v);
        return ~v + PROD_W'(1);
    endfunction

    // The most-negative value maps onto 2^(WIDTH-1), which still fits unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             is_signed);
        return (is_signed && v[WIDTH-1]) ? negate(v) : v;
    endfunction

    assign accept    = (state == IDLE) && Start && !Flush;
    assign div_zero  = Op[1] && (Operand2 == '0);
    assign last_iter = (count == CNT_W'(WIDTH - 1));

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = div_zero ? FINISH : COMPUTE;
                end
            end
            COMPUTE: begin
                if (Flush) begin
                    state_next = IDLE;
                end else if (last_iter) begin
                    state_next = FINISH;
                end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        Busy = accept || (state == COMPUTE);
        Done = (state == FINISH);
    end

    // One iteration: part/shreg hold product-high/low for multiply and
    // remainder/quotient for divide. The borrow bit of div_diff says whether
    // the divisor fits into the shifted partial remainder.
    always_comb begin
        mul_sum   = {1'b0, part} + (shreg[0] ? {1'b0, operand} : '0);
        div_shift = {part, shreg[WIDTH-1]};
        div_diff  = div_shift - {1'b0, operand};
        div_fits  = ~div_diff[WIDTH];
        if (is_div) begin
            part_next  = div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            shreg_next = {shreg[WIDTH-2:0], div_fits};
        end else begin
            part_next  = mul_sum[WIDTH:1];
            shreg_next = {mul_sum[0], shreg[WIDTH-1:1]};
        end
        product = neg_res ? negate_wide({part_next, shreg_next}) : {part_next, shreg_next};
        if (is_div) begin
            res1_final = neg_res ? negate(shreg_next) : shreg_next;
            res2_final = neg_rem ? negate(part_next)  : part_next;
        end else begin
            res1_final = product[WIDTH-1:0];
            res2_final = product[PROD_W-1:WIDTH];
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            count   <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            operand <= '0;
            part    <= '0;
            shreg   <= '0;
            Result1 <= '0;
            Result2 <= '0;
        end else if (accept) begin
            count   <= '0;
            is_div  <= Op[1];
            neg_res <= Op[0] & (Operand1[WIDTH-1] ^ Operand2[WIDTH-1]);
            neg_rem <= Op[0] & Operand1[WIDTH-1];
            part    <= '0;
            operand <= Op[1] ? magnitude(Operand2, Op[0]) : magnitude(Operand1, Op[0]);
            shreg   <= Op[1] ? magnitude(Operand1, Op[0]) : magnitude(Operand2, Op[0]);
            if (div_zero) begin
                Result1 <= DIV0_QUOTIENT;
                Result2 <= Operand1;
            end
        end else if ((state == COMPUTE) && !Flush) begin
            count <= count + CNT_W'(1);
            part  <= part_next;
            shreg <= shreg_next;
            if (last_iter) begin
                Result1 <= res1_final;
                Result2 <= res2_final;
            end
        end
    end

endmodule

// File: tb/tb_mcycle_unit.sv
// Bench for mcycle_unit: a 32-bit and an 8-bit instance, directed operations,
// and a cycle-level reference model compared on every falling edge.
module tb_mcycle_unit;

    logic        clk;
    logic        rst_n [2];
    logic        start [2];
    logic        flush [2];
    logic [1:0]  op    [2];
    logic [31:0] a     [2];
    logic [31:0] b     [2];
    logic        busy_o[2];
    logic        done_o[2];
    logic [31:0] r1_a, r2_a;
    logic [7:0]  r1_b, r2_b;

    int n_vec = 0;
    int n_bad = 0;
    bit cmp_on = 0;

    mcycle_unit #(.WIDTH(32)) u_w32 (
        .CLK(clk), .Reset_n(rst_n[0]), .Start(start[0]), .Op(op[0]), .Flush(flush[0]),
        .Operand1(a[0]), .Operand2(b[0]), .Result1(r1_a), .Result2(r2_a),
        .Busy(busy_o[0]), .Done(done_o[0]));

    mcycle_unit #(.WIDTH(8)) u_w8 (
        .CLK(clk), .Reset_n(rst_n[1]), .Start(start[1]), .Op(op[1]), .Flush(flush[1]),
        .Operand1(a[1][7:0]), .Operand2(b[1][7:0]), .Result1(r1_b), .Result2(r2_b),
        .Busy(busy_o[1]), .Done(done_o[1]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int wid(input int i);
        return (i == 0) ? 32 : 8;
    endfunction

    function automatic logic [31:0] act_r1(input int i);
        return (i == 0) ? r1_a : {24'd0, r1_b};
    endfunction

    function automatic logic [31:0] act_r2(input int i);
        return (i == 0) ? r2_a : {24'd0, r2_b};
    endfunction

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endfunction

    // Reference arithmetic with plain 64-bit integers.
    function automatic void ref_calc(input int w, input logic [1:0] o,
                                     input logic [31:0] x, input logic [31:0] y,
                                     output logic [31:0] e1, output logic [31:0] e2,
                                     output bit dz);
        logic [63:0] mask, sx, sy, p, t;
        longint      q, r;
        mask = (64'd1 << w) - 64'd1;
        sx   = {32'd0, x} & mask;
        sy   = {32'd0, y} & mask;
        if (o[0] && sx[w-1]) sx = sx | ~mask;
        if (o[0] && sy[w-1]) sy = sy | ~mask;
        dz = o[1] && (({32'd0, y} & mask) == 64'd0);
        if (!o[1]) begin
            p  = sx * sy;
            e1 = p[31:0] & mask[31:0];
            t  = p >> w;
            e2 = t[31:0] & mask[31:0];
        end else if (dz) begin
            e1 = mask[31:0];
            e2 = x & mask[31:0];
        end else begin
            q  = longint'(sx) / longint'(sy);
            r  = longint'(sx) % longint'(sy);
            t  = q;
            e1 = t[31:0] & mask[31:0];
            t  = r;
            e2 = t[31:0] & mask[31:0];
        end
    endfunction

    // Timing model: Busy for the Start cycle plus WIDTH compute cycles, then a
    // one-cycle Done with fresh results; divide-by-zero finishes straight away.
    int          left   [2];
    bit          mdone  [2];
    logic [31:0] m_r1   [2];
    logic [31:0] m_r2   [2];
    logic [31:0] p_r1   [2];
    logic [31:0] p_r2   [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            left[i] = 0; mdone[i] = 0; m_r1[i] = 0; m_r2[i] = 0; p_r1[i] = 0; p_r2[i] = 0;
        end
    end

    always @(posedge clk) begin
        logic [31:0] t1, t2;
        bit          dz;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n[i]) begin
                left[i] <= 0; mdone[i] <= 0; m_r1[i] <= 0; m_r2[i] <= 0;
            end else if (left[i] > 0) begin
                if (flush[i]) begin
                    left[i] <= 0;
                end else begin
                    left[i] <= left[i] - 1;
                    if (left[i] == 1) begin
                        mdone[i] <= 1; m_r1[i] <= p_r1[i]; m_r2[i] <= p_r2[i];
                    end
                end
            end else if (mdone[i]) begin
                mdone[i] <= 0;
            end else if (start[i] && !flush[i]) begin
                ref_calc(wid(i), op[i], a[i], b[i], t1, t2, dz);
                if (dz) begin
                    mdone[i] <= 1; m_r1[i] <= t1; m_r2[i] <= t2;
                end else begin
                    left[i] <= wid(i); p_r1[i] <= t1; p_r2[i] <= t2;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("busy[%0d]", i), {63'd0, busy_o[i]},
                    {63'd0, rst_n[i] && (left[i] > 0 || (!mdone[i] && start[i] && !flush[i]))});
                chk($sformatf("done[%0d]", i), {63'd0, done_o[i]}, {63'd0, rst_n[i] && mdone[i]});
                chk($sformatf("result1[%0d]", i), {32'd0, act_r1(i)}, {32'd0, rst_n[i] ? m_r1[i] : 32'd0});
                chk($sformatf("result2[%0d]", i), {32'd0, act_r2(i)}, {32'd0, rst_n[i] ? m_r2[i] : 32'd0});
            end
        end
    end

    task automatic run_op(input int i, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] e1, input logic [31:0] e2,
                          input int elat, input string nm);
        int cyc;
        @(posedge clk); #1;
        start[i] = 1'b1; op[i] = o; a[i] = x; b[i] = y;
        #1 chk({nm, " busy at start"}, {63'd0, busy_o[i]}, 64'd1);
        cyc = 0;
        while (1) begin
            @(posedge clk); #1;
            start[i] = 1'b0;
            cyc++;
            if (done_o[i] || cyc >= 200) break;
        end
        if (!done_o[i]) begin
            n_vec++; n_bad++;
            $display("FAIL %s timeout: no Done within %0d cycles", nm, cyc);
        end else begin
            chk({nm, " latency"}, 64'(cyc), 64'(elat));
            chk({nm, " result1"}, {32'd0, act_r1(i)}, {32'd0, e1});
            chk({nm, " result2"}, {32'd0, act_r2(i)}, {32'd0, e2});
        end
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 0; start[i] = 0; flush[i] = 0; op[i] = 0; a[i] = 0; b[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset busy[%0d]", i), {63'd0, busy_o[i]}, 64'd0);
            chk($sformatf("reset done[%0d]", i), {63'd0, done_o[i]}, 64'd0);
            chk($sformatf("reset result1[%0d]", i), {32'd0, act_r1(i)}, 64'd0);
            chk($sformatf("reset result2[%0d]", i), {32'd0, act_r2(i)}, 64'd0);
        end
        rst_n[0] = 1; rst_n[1] = 1;
        cmp_on = 1;

        run_op(0, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 33, "umul max");
        run_op(0, 2'b01, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, 32'hFFFFFFFF, 33, "smul -3*7");
        run_op(0, 2'b01, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 33, "smul minneg^2");
        run_op(0, 2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 33, "sdiv -7/2");
        run_op(0, 2'b11, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 33, "sdiv 7/-2");
        run_op(0, 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 33, "sdiv overflow");
        run_op(0, 2'b10, 32'd100,      32'd7,        32'd14,       32'd2,        33, "udiv 100/7");
        run_op(0, 2'b10, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1,  "udiv 5/0");
        run_op(0, 2'b11, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB, 1,  "sdiv -5/0");

        // Flush while count=10 (compute cycle 11).
        @(posedge clk); #1;
        start[0] = 1; op[0] = 2'b10; a[0] = 32'd1000; b[0] = 32'd3;
        seen = 0;
        for (int c = 1; c <= 11; c++) begin
            @(posedge clk); #1;
            start[0] = 0;
            if (c == 11) flush[0] = 1;
        end
        @(posedge clk); #1;
        flush[0] = 0;
        #1 chk("flush busy low", {63'd0, busy_o[0]}, 64'd0);
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done_o[0]) seen = 1;
        end
        chk("flush no done", {63'd0, seen}, 64'd0);
        chk("flush result1 kept", {32'd0, r1_a}, {32'd0, 32'hFFFFFFFF});
        chk("flush result2 kept", {32'd0, r2_a}, {32'd0, 32'hFFFFFFFB});

        // Start together with Flush in IDLE is dropped.
        @(posedge clk); #1;
        start[0] = 1; flush[0] = 1; op[0] = 2'b00; a[0] = 32'd9; b[0] = 32'd9;
        #1 chk("start+flush busy", {63'd0, busy_o[0]}, 64'd0);
        @(posedge clk); #1;
        start[0] = 0; flush[0] = 0;
        #1 chk("start+flush no capture", {63'd0, busy_o[0] | done_o[0]}, 64'd0);
        run_op(0, 2'b00, 32'd12345, 32'd678, 32'd8369910, 32'd0, 33, "umul after flush");

        // 8-bit instance.
        run_op(1, 2'b11, 32'h80, 32'hFF, 32'h80, 32'h00, 9, "w8 sdiv overflow");
        run_op(1, 2'b00, 32'hFF, 32'hFF, 32'h01, 32'hFE, 9, "w8 umul max");
        run_op(1, 2'b01, 32'hFD, 32'h05, 32'hF1, 32'hFF, 9, "w8 smul -3*5");

        // Reset pulled low while count=4 (compute cycle 5).
        @(posedge clk); #1;
        start[1] = 1; op[1] = 2'b10; a[1] = 32'd200; b[1] = 32'd7;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            start[1] = 0;
        end
        rst_n[1] = 0;
        #1;
        chk("w8 reset busy", {63'd0, busy_o[1]}, 64'd0);
        chk("w8 reset done", {63'd0, done_o[1]}, 64'd0);
        chk("w8 reset result1", {56'd0, r1_b}, 64'd0);
        chk("w8 reset result2", {56'd0, r2_b}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n[1] = 1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (done_o[1]) seen = 1;
        end
        chk("w8 no done after reset", {63'd0, seen}, 64'd0);
        run_op(1, 2'b10, 32'd200, 32'd7, 32'd28, 32'd4, 9, "w8 udiv 200/7");

        repeat (3) @(posedge clk);
        #1 cmp_on = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
